// File: rtl/barcode_rdr.sv
// rtl/barcode_rdr.sv - serial barcode station-ID reader
//
// Receives a start bit plus 8 data bits (MSB first) on BC. The low time of
// the start bit sets the sampling period; each data bit is sampled that many
// clocks after its own falling edge. Frames whose top two bits are not 00
// are discarded.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   BC         serial barcode line, asynchronous to clk, idles high
//   clr_ID_vld one-cycle synchronous clear of ID_vld
//   ID         last received valid station ID
//   ID_vld     ID holds a valid, unconsumed station ID
module barcode_rdr #(
  parameter int CNT_W = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld
);

  typedef enum logic [2:0] {
    IDLE,
    MEAS,
    WAIT_FALL,
    SAMPLE,
    DONE
  } state_t;

  state_t state, nxt;

  logic             bc_ff1, bc_s, bc_prev;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;

  logic cnt_clr, cnt_inc, period_ld, bit_clr, shift_en, id_ld;
  logic cnt_max;

  // Flops preset to 1 so reset release never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bc_ff1  <= 1'b1;
      bc_s    <= 1'b1;
      bc_prev <= 1'b1;
    end else begin
      bc_ff1  <= BC;
      bc_s    <= bc_ff1;
      bc_prev <= bc_s;
    end
  end

  assign fall    = bc_prev & ~bc_s;
  assign cnt_max = &cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    period_ld = 1'b0;
    bit_clr   = 1'b0;
    shift_en  = 1'b0;
    id_ld     = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          cnt_clr = 1'b1;
          nxt     = MEAS;
        end
      end
      MEAS: begin
        if (cnt_max) begin
          nxt = IDLE;
        end else if (bc_s) begin
          // A zero-length start bit gives no usable sampling period.
          if (cnt == '0) begin
            nxt = IDLE;
          end else begin
            period_ld = 1'b1;
            bit_clr   = 1'b1;
            nxt       = WAIT_FALL;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_FALL: begin
        if (cnt_max) begin
          nxt = IDLE;
        end else if (fall) begin
          cnt_clr = 1'b1;
          nxt     = SAMPLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      SAMPLE: begin
        // Edges here are ignored; only the sample point matters.
        cnt_inc = 1'b1;
        if (cnt == period) begin
          shift_en = 1'b1;
          nxt      = (bit_cnt == 3'd7) ? DONE : WAIT_FALL;
        end
      end
      DONE: begin
        id_ld = (shift_reg[7:6] == 2'b00);
        nxt   = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // cnt saturates at all-ones so a stuck line is caught as a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_inc && !cnt_max) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period    <= '0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      if (period_ld) period <= cnt;
      if (bit_clr) begin
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (shift_en) shift_reg <= {shift_reg[6:0], bc_s};
    end
  end

  // A load in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ID     <= 8'h00;
      ID_vld <= 1'b0;
    end else if (id_ld) begin
      ID     <= shift_reg;
      ID_vld <= 1'b1;
    end else if (clr_ID_vld) begin
      ID_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_barcode_rdr.sv
// tb/tb_barcode_rdr.sv - self-checking bench for barcode_rdr
module tb_barcode_rdr;

  localparam int CNT_W = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       BC;
  logic       clr_ID_vld;
  logic [7:0] ID;
  logic       ID_vld;

  always #10 clk = ~clk;

  barcode_rdr #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .BC         (BC),
    .clr_ID_vld (clr_ID_vld),
    .ID         (ID),
    .ID_vld     (ID_vld)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] exp_id;
  logic       exp_vld;

  int   vld_rises = 0;
  int   vld_falls = 0;
  logic vld_prev  = 1'b0;

  always @(negedge clk) begin
    if (ID_vld === 1'b1 && vld_prev === 1'b0) vld_rises++;
    if (ID_vld === 1'b0 && vld_prev === 1'b1) vld_falls++;
    vld_prev = ID_vld;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a frame is accepted only when its top two bits are 00.
  task automatic model_frame(input logic [7:0] data);
    if (data[7:6] == 2'b00) begin
      exp_id  = data;
      exp_vld = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      BC         = 1'b1;
      clr_ID_vld = 1'b0;
    end
  endtask

  // Cell of t clocks: start = low t/2; '1' = low t/4; '0' = low 3t/4.
  // With clr_done, clr_ID_vld is raised exactly on the DONE cycle:
  // final fall + 3 sync/edge clocks + period (t/2-1) + 1.
  task automatic send_frame(input logic [7:0] data, input int t, input bit clr_done,
                            input bit glitch, input int ncells);
    int   low;
    logic b;
    for (int c = 0; c < ncells; c++) begin
      b = 1'b0;
      if (c == 0) begin
        low = t / 2;
      end else begin
        b   = data[8-c];
        low = b ? t / 4 : (3 * t) / 4;
      end
      for (int i = 0; i < t; i++) begin
        @(negedge clk);
        BC = (i < low) ? 1'b0 : 1'b1;
        if (glitch && c > 0 && b && (i == t / 4 + 2 || i == t / 4 + 3)) BC = 1'b0;
        clr_ID_vld = (clr_done && c == 8 && i == t / 2 + 3);
      end
    end
    clr_ID_vld = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_ID_vld = 1'b1;
    @(negedge clk);
    clr_ID_vld = 1'b0;
    exp_vld    = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int         t;
    int         r0;
    int         f0;

    rst        = 1'b1;
    BC         = 1'b1;
    clr_ID_vld = 1'b0;
    exp_id     = 8'h00;
    exp_vld    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_id", {24'd0, ID}, {24'd0, exp_id});
    check("reset_vld", {31'd0, ID_vld}, {31'd0, exp_vld});
    rst = 1'b0;
    idle(5);
    check("idle_vld", {31'd0, ID_vld}, {31'd0, exp_vld});

    // Basic valid frame.
    send_frame(8'h15, 64, 1'b0, 1'b0, 9);
    model_frame(8'h15);
    idle(4);
    check("f15_id", {24'd0, ID}, {24'd0, exp_id});
    check("f15_vld", {31'd0, ID_vld}, {31'd0, exp_vld});

    // Clear: ID_vld drops next clock, ID kept.
    pulse_clr();
    check("clr_vld", {31'd0, ID_vld}, {31'd0, exp_vld});
    check("clr_id", {24'd0, ID}, {24'd0, exp_id});

    // Invalid frame discarded.
    send_frame(8'hC5, 48, 1'b0, 1'b0, 9);
    model_frame(8'hC5);
    idle(4);
    check("fC5_id", {24'd0, ID}, {24'd0, exp_id});
    check("fC5_vld", {31'd0, ID_vld}, {31'd0, exp_vld});

    // Clear coincident with DONE: set wins.
    send_frame(8'h2C, 40, 1'b1, 1'b0, 9);
    model_frame(8'h2C);
    idle(4);
    check("coin_id", {24'd0, ID}, {24'd0, exp_id});
    check("coin_vld", {31'd0, ID_vld}, {31'd0, exp_vld});

    // Zero-length start bit is dropped; next frame decodes.
    pulse_clr();
    @(negedge clk);
    BC = 1'b0;
    @(negedge clk);
    BC = 1'b1;
    idle(30);
    check("p0_vld", {31'd0, ID_vld}, {31'd0, exp_vld});
    send_frame(8'h29, 32, 1'b0, 1'b0, 9);
    model_frame(8'h29);
    idle(4);
    check("p0_next_id", {24'd0, ID}, {24'd0, exp_id});
    check("p0_next_vld", {31'd0, ID_vld}, {31'd0, exp_vld});

    // Lone falling edge then line high: timeout, then a good frame.
    pulse_clr();
    @(negedge clk);
    BC = 1'b0;
    repeat (16) @(negedge clk);
    BC = 1'b1;
    idle((1 << CNT_W) + 100);
    check("to_vld", {31'd0, ID_vld}, {31'd0, exp_vld});
    send_frame(8'h07, 32, 1'b0, 1'b0, 9);
    model_frame(8'h07);
    idle(4);
    check("to_next_id", {24'd0, ID}, {24'd0, exp_id});
    check("to_next_vld", {31'd0, ID_vld}, {31'd0, exp_vld});

    // Back-to-back frames, no clear: ID_vld never drops.
    send_frame(8'h01, 32, 1'b0, 1'b0, 9);
    model_frame(8'h01);
    check("b2b1_id", {24'd0, ID}, {24'd0, exp_id});
    f0 = vld_falls;
    send_frame(8'h3F, 32, 1'b0, 1'b0, 9);
    model_frame(8'h3F);
    idle(4);
    check("b2b2_id", {24'd0, ID}, {24'd0, exp_id});
    check("b2b2_vld", {31'd0, ID_vld}, {31'd0, exp_vld});
    check("b2b_no_drop", vld_falls - f0, 0);

    // Reset during bit 4 of 0x2A, then a clean 0x11.
    send_frame(8'h2A, 32, 1'b0, 1'b0, 5);
    repeat (5) @(negedge clk) BC = 1'b0;
    @(negedge clk);
    rst     = 1'b1;
    BC      = 1'b1;
    exp_id  = 8'h00;
    exp_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_id", {24'd0, ID}, {24'd0, exp_id});
    check("rst_mid_vld", {31'd0, ID_vld}, {31'd0, exp_vld});
    rst = 1'b0;
    idle(10);
    r0 = vld_rises;
    send_frame(8'h11, 32, 1'b0, 1'b0, 9);
    model_frame(8'h11);
    idle(4);
    check("rst_next_id", {24'd0, ID}, {24'd0, exp_id});
    check("rst_next_vld", {31'd0, ID_vld}, {31'd0, exp_vld});
    check("rst_one_rise", vld_rises - r0, 1);

    // Random frames, periods and glitches.
    for (int k = 0; k < 10; k++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) d[7:6] = 2'b00;
      t = 4 * $urandom_range(6, 16);
      send_frame(d, t, 1'b0, 1'($urandom_range(0, 1)), 9);
      model_frame(d);
      idle($urandom_range(2, 20));
      check("rnd_id", {24'd0, ID}, {24'd0, exp_id});
      check("rnd_vld", {31'd0, ID_vld}, {31'd0, exp_vld});
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr();
        check("rnd_clr_vld", {31'd0, ID_vld}, {31'd0, exp_vld});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
